// File: rtl/invaders_march_controller.sv
`timescale 1ns/1ps
// invaders_march_controller: frame-rate sequencer for the invader formation.
//   Decides which frames step the formation sideways, when it drops a row and
//   reverses, and how fast it marches as invaders are destroyed.
// Ports:
//   clk, resetN (async, active-low)
//   startOfFrame, waveStart, playerHit : one-cycle pulses in
//   aliveCount                         : invaders currently alive
//   atRightEdge, atLeftEdge            : formation touches a play-field limit
//   stepPulse, dropPulse               : one-cycle motion commands (registered)
//   dirLeft                            : 0 = marching right, 1 = marching left
//   period                             : current step period in frames
//   waveClear                          : level, wave finished
//   state                              : FSM code (0 IDLE,1 MARCH,2 DROP,3 PAUSE,4 CLEARED)
// Optional feature macro: MARCH_PAUSE_EN (freeze the march after a player hit).
module invaders_march_controller #(
  parameter int MAX_ALIVE    = 40,
  parameter int ALIVE_W      = 6,
  parameter int BASE_PERIOD  = 20,
  parameter int MIN_PERIOD   = 1,
  parameter int SPEEDUP_DIV  = 2,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               waveStart,
  input  logic [ALIVE_W-1:0] aliveCount,
  input  logic               atRightEdge,
  input  logic               atLeftEdge,
  input  logic               playerHit,
  output logic               stepPulse,
  output logic               dropPulse,
  output logic               dirLeft,
  output logic [4:0]         period,
  output logic               waveClear,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MARCH   = 3'd1,
    S_DROP    = 3'd2,
    S_PAUSE   = 3'd3,
    S_CLEARED = 3'd4
  } state_t;

  localparam logic [31:0] MAX_A  = 32'(MAX_ALIVE);
  localparam logic [31:0] BASE_P = 32'(BASE_PERIOD);
  localparam logic [31:0] MIN_P  = 32'(MIN_PERIOD);
  localparam logic [31:0] DIV    = 32'(SPEEDUP_DIV);

  state_t      r_state, w_state_nxt;
  logic        r_step, r_drop, r_dir, r_clear;
  logic [4:0]  r_frame_cnt, r_period;
  logic        w_step_nxt, w_drop_nxt, w_dir_nxt, w_clear_nxt;
  logic [4:0]  w_frame_nxt;
  logic        w_zero, w_last, w_edge, w_hit;
  logic [31:0] w_alive_ext, w_alive_c, w_reduce, w_period_full;

  assign stepPulse = r_step;
  assign dropPulse = r_drop;
  assign dirLeft   = r_dir;
  assign period    = r_period;
  assign waveClear = r_clear;
  assign state     = r_state;

  // Period: clamp the alive count first so the subtraction never underflows,
  // then saturate at MIN_PERIOD.
  always_comb begin
    w_alive_ext   = 32'(aliveCount);
    w_alive_c     = (w_alive_ext > MAX_A) ? MAX_A : w_alive_ext;
    w_reduce      = (MAX_A - w_alive_c) / DIV;
    w_period_full = ((w_reduce + MIN_P) >= BASE_P) ? MIN_P : (BASE_P - w_reduce);
  end

  assign w_zero = (aliveCount == '0);
  // Step decision point: frameCnt+1 has reached the (possibly just shortened) period.
  assign w_last = (({1'b0, r_frame_cnt} + 6'd1) >= {1'b0, r_period});
  // Only the edge in the current marching direction matters.
  assign w_edge = r_dir ? atLeftEdge : atRightEdge;

`ifdef MARCH_PAUSE_EN
  localparam int PCW = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);
  logic [PCW-1:0] r_pause_cnt, w_pause_nxt;
  logic           r_ret_drop, w_ret_nxt;  // 1: resume in DROP (drop still pending)
  logic           w_pause_done;
  assign w_hit        = playerHit && ((r_state == S_MARCH) || (r_state == S_DROP));
  assign w_pause_done = startOfFrame && (r_pause_cnt <= PCW'(1));
`else
  logic w_unused_ok;
  assign w_unused_ok = playerHit ^ (PAUSE_FRAMES != 0);
  assign w_hit       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; priority: wave cleared > player hit > frame processing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (waveStart) w_state_nxt = S_MARCH;
      S_MARCH: begin
        if (w_zero)                               w_state_nxt = S_CLEARED;
        else if (w_hit)                           w_state_nxt = S_PAUSE;
        else if (startOfFrame && w_last && w_edge) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (w_zero)            w_state_nxt = S_CLEARED;
        else if (w_hit)        w_state_nxt = S_PAUSE;
        else if (startOfFrame) w_state_nxt = S_MARCH;
      end
`ifdef MARCH_PAUSE_EN
      S_PAUSE: begin
        if (w_zero)            w_state_nxt = S_CLEARED;
        else if (w_pause_done) w_state_nxt = r_ret_drop ? S_DROP : S_MARCH;
      end
`endif
      S_CLEARED: if (waveStart) w_state_nxt = S_MARCH;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_step_nxt  = 1'b0;
    w_drop_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_clear_nxt = r_clear;
    w_frame_nxt = r_frame_cnt;
`ifdef MARCH_PAUSE_EN
    w_pause_nxt = r_pause_cnt;
    w_ret_nxt   = r_ret_drop;
`endif
    case (r_state)
      S_IDLE: begin
        if (waveStart) begin
          w_frame_nxt = '0;
          w_dir_nxt   = 1'b0;
        end
      end
      S_MARCH: begin
        if (w_zero) begin
          w_clear_nxt = 1'b1;
        end else if (w_hit) begin
`ifdef MARCH_PAUSE_EN
          w_pause_nxt = PCW'(PAUSE_FRAMES);
          w_ret_nxt   = 1'b0;
`endif
        end else if (startOfFrame) begin
          if (!w_last) begin
            w_frame_nxt = r_frame_cnt + 5'd1;
          end else begin
            w_frame_nxt = '0;
            w_step_nxt  = !w_edge;
          end
        end
      end
      S_DROP: begin
        if (w_zero) begin
          w_clear_nxt = 1'b1;
        end else if (w_hit) begin
`ifdef MARCH_PAUSE_EN
          w_pause_nxt = PCW'(PAUSE_FRAMES);
          w_ret_nxt   = 1'b1;
`endif
        end else if (startOfFrame) begin
          w_drop_nxt  = 1'b1;
          w_dir_nxt   = !r_dir;
          w_frame_nxt = '0;
        end
      end
`ifdef MARCH_PAUSE_EN
      S_PAUSE: begin
        if (w_zero) begin
          w_clear_nxt = 1'b1;
        end else if (w_pause_done) begin
          w_pause_nxt = '0;
          w_frame_nxt = '0;
        end else if (startOfFrame) begin
          w_pause_nxt = r_pause_cnt - PCW'(1);
        end
      end
`endif
      S_CLEARED: begin
        if (waveStart) begin
          w_clear_nxt = 1'b0;
          w_dir_nxt   = 1'b0;
          w_frame_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_step      <= 1'b0;
      r_drop      <= 1'b0;
      r_dir       <= 1'b0;
      r_clear     <= 1'b0;
      r_frame_cnt <= '0;
      r_period    <= 5'(BASE_PERIOD);
    end else begin
      r_step      <= w_step_nxt;
      r_drop      <= w_drop_nxt;
      r_dir       <= w_dir_nxt;
      r_clear     <= w_clear_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_period    <= 5'(w_period_full);
    end
  end

`ifdef MARCH_PAUSE_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pause_cnt <= '0;
      r_ret_drop  <= 1'b0;
    end else begin
      r_pause_cnt <= w_pause_nxt;
      r_ret_drop  <= w_ret_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_invaders_march_controller.sv
`timescale 1ns/1ps
// Testbench for invaders_march_controller: directed frame sequences; expected
// step/drop pulses are queued as stimulus is issued and a monitor pops and
// compares each pulse the DUT produces.
module tb_invaders_march_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, waveStart, atRightEdge, atLeftEdge, playerHit;
  logic [5:0] aliveCount;
  logic       stepPulse, dropPulse, dirLeft, waveClear;
  logic [4:0] period;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  typedef struct packed {
    logic        is_drop;
    logic        dir;
    logic [31:0] frame;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  invaders_march_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .waveStart    (waveStart),
    .aliveCount   (aliveCount),
    .atRightEdge  (atRightEdge),
    .atLeftEdge   (atLeftEdge),
    .playerHit    (playerHit),
    .stepPulse    (stepPulse),
    .dropPulse    (dropPulse),
    .dirLeft      (dirLeft),
    .period       (period),
    .waveClear    (waveClear),
    .state        (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic is_drop, input logic dir, input int frame);
    exp_t e;
    e.is_drop = is_drop;
    e.dir     = dir;
    e.frame   = 32'(frame);
    exp_q.push_back(e);
  endtask

  // One frame = startOfFrame for one cycle, then two quiet cycles.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      startOfFrame = 1'b1;
      frame_no++;
      @(negedge clk);
      startOfFrame = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_wave();
    @(negedge clk) waveStart = 1'b1;
    @(negedge clk) waveStart = 1'b0;
  endtask

  task automatic set_alive(input logic [5:0] v);
    @(negedge clk) aliveCount = v;
    @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the queue, appear in the cycle
  // right after the startOfFrame cycle (startOfFrame still high here), and
  // last one cycle only (a longer pulse would pop an extra entry).
  always @(posedge clk) begin
    #1;
    if (stepPulse || dropPulse) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse: unexpected step=%0b drop=%0b dir=%0b at frame %0d, none expected",
                 stepPulse, dropPulse, dirLeft, frame_no);
      end else begin
        mon_e = exp_q.pop_front();
        if (dropPulse !== mon_e.is_drop || stepPulse !== !mon_e.is_drop ||
            dirLeft !== mon_e.dir || frame_no !== int'(mon_e.frame) || startOfFrame !== 1'b1) begin
          errors++;
          $display("FAIL pulse: got step=%0b drop=%0b dir=%0b frame=%0d sof=%0b expected drop=%0b dir=%0b frame=%0d sof=1",
                   stepPulse, dropPulse, dirLeft, frame_no, startOfFrame,
                   mon_e.is_drop, mon_e.dir, mon_e.frame);
        end
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    resetN = 1'b1; startOfFrame = 1'b0; waveStart = 1'b0;
    atRightEdge = 1'b0; atLeftEdge = 1'b0; playerHit = 1'b0;
    aliveCount = 6'd40;
    #2 resetN = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_step", 32'(stepPulse), 0);
    check("rst_drop", 32'(dropPulse), 0);
    check("rst_dir", 32'(dirLeft), 0);
    check("rst_clear", 32'(waveClear), 0);
    check("rst_period", 32'(period), 20);
    check("rst_state", 32'(state), 0);
    @(negedge clk) resetN = 1'b1;
    frames(2);
    check("idle_no_start", 32'(state), 0);

    // Full formation: steps on frames 20, 40, 60; wrong-direction edge ignored
    pulse_wave();
    check("start_state", 32'(state), 1);
    check("full_period", 32'(period), 20);
    base = frame_no;
    push(1'b0, 1'b0, base + 20);
    push(1'b0, 1'b0, base + 40);
    push(1'b0, 1'b0, base + 60);
    atLeftEdge = 1'b1;
    frames(60);
    atLeftEdge = 1'b0;
    check("march_dir", 32'(dirLeft), 0);

    // Right edge at the decision point: no step, drop next frame, step 20 later
    base = frame_no;
    frames(19);
    atRightEdge = 1'b1;
    push(1'b1, 1'b1, base + 21);
    push(1'b0, 1'b1, base + 41);
    frames(1);
    check("edge_to_drop", 32'(state), 2);
    frames(21);
    check("after_drop_state", 32'(state), 1);
    check("after_drop_dir", 32'(dirLeft), 1);

    // Speed-up (right edge still high but marching left)
    set_alive(6'd20);
    check("period_20_alive", 32'(period), 10);
    push(1'b0, 1'b1, frame_no + 10);
    frames(10);
    set_alive(6'd1);
    check("period_1_alive", 32'(period), 1);
    push(1'b0, 1'b1, frame_no + 1);
    push(1'b0, 1'b1, frame_no + 2);
    push(1'b0, 1'b1, frame_no + 3);
    frames(3);
    set_alive(6'd21);
    check("period_floor_div", 32'(period), 11);
    set_alive(6'd63);
    check("period_clamp_max", 32'(period), 20);
    atRightEdge = 1'b0;

    // Wave clear mid-march, then restart
    set_alive(6'd0);
    check("clear_state", 32'(state), 4);
    check("clear_flag", 32'(waveClear), 1);
    check("period_min_clamp", 32'(period), 1);
    frames(3);
    check("clear_hold", 32'(state), 4);
    aliveCount = 6'd40;
    pulse_wave();
    check("restart_state", 32'(state), 1);
    check("restart_clear", 32'(waveClear), 0);
    check("restart_dir", 32'(dirLeft), 0);

    // Player hit while in DROP
    base = frame_no;
    frames(19);
    atRightEdge = 1'b1;
    frames(1);
    check("hit_pre_drop", 32'(state), 2);
    @(negedge clk) playerHit = 1'b1;
    @(negedge clk) playerHit = 1'b0;
`ifdef MARCH_PAUSE_EN
    check("pause_state", 32'(state), 3);
    push(1'b1, 1'b1, base + 81);
    frames(60);
    check("pause_return", 32'(state), 2);
    frames(1);
`else
    check("hit_ignored", 32'(state), 2);
    push(1'b1, 1'b1, base + 21);
    frames(1);
`endif
    atRightEdge = 1'b0;
    check("hit_after_drop", 32'(state), 1);

    // Reset mid-DROP
    set_alive(6'd20);
    atLeftEdge = 1'b1;
    frames(10);
    check("pre_reset_state", 32'(state), 2);
    check("pre_reset_period", 32'(period), 10);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_dir", 32'(dirLeft), 0);
    check("mid_rst_period", 32'(period), 20);
    check("mid_rst_drop", 32'(dropPulse), 0);
    frames(1);
    @(negedge clk) resetN = 1'b1;
    atLeftEdge = 1'b0;
    frames(3);
    check("post_rst_idle", 32'(state), 0);
    pulse_wave();
    check("post_rst_start", 32'(state), 1);
    check("post_rst_period", 32'(period), 10);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d pulses still pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
